arbiter_rr_rts: RTL

- Parametrised round-robin output-port arbiter for the NoC router; one instance per output port.
- Chooses one of N_PORTS input requesters, drives the crossbar select and runs the RTS/DCTS flow-control handshake toward the downstream router.
- Successor to the fixed 5-port (N/E/W/S/L) one-hot arbiter. Adds parametrised port count, a round-robin pointer out of IDLE, and an optional hold limit so one port cannot starve the others.

---
 rtl/arbiter_pkg.sv | 25 ++
 rtl/arbiter_rr_rts_pick.sv | 20 ++
 rtl/arbiter_rr_rts.sv | 105 ++++++++++
 3 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the round-robin RTS/DCTS output-port arbiter.
package arbiter_pkg;

    localparam int HOLD_W = 8;

    typedef enum logic {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_kind_e;

    // Circular find-first-set over the low n bits of req, starting at start.
    // Returns {valid, index}; index is meaningless when valid is 0.
    function automatic logic [4:0] rr_pick(input logic [15:0] req,
                                           input logic [3:0]  start,
                                           input logic [4:0]  n);
        logic [4:0] res;
        logic [4:0] idx;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            idx = {1'b0, start} + 5'(i);
            if (idx >= n) idx = idx - n;
            if ((5'(i) < n) && !res[4] && req[idx[3:0]])
                res = {1'b1, idx[3:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/arbiter_rr_rts_pick.sv
// Combinational circular priority pick: first set request at or after i_start.
module rr_priority_pick
    import arbiter_pkg::*;
#(
    parameter int N_PORTS = 5,
    parameter int IDX_W   = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]   i_start,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    logic [4:0] w_res;

    assign w_res   = rr_pick(16'(i_req), 4'(i_start), 5'(N_PORTS));
    assign o_valid = w_res[4];
    assign o_idx   = IDX_W'(w_res[3:0]);

endmodule

// File: rtl/arbiter_rr_rts.sv
// Round-robin output-port arbiter with RTS/DCTS handshake toward the next router.
// Optional hold limit forcing rotation: define ARB_HOLD_LIMIT_EN.
module arbiter_rr_rts
    import arbiter_pkg::*;
#(
    parameter int N_PORTS  = 5,
    parameter int HOLD_MAX = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_PORTS-1:0] req,
    input  logic               dcts,
    output logic [N_PORTS-1:0] grant,
    output logic [N_PORTS-1:0] xbar_sel,
    output logic               rts,
    output logic               busy
);

    localparam int IDX_W = $clog2(N_PORTS);

    state_kind_e        r_state;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic               r_rts;

    logic [N_PORTS-1:0] w_owner_oh;
    logic [IDX_W-1:0]   w_ptr_nx;
    logic [IDX_W-1:0]   w_own_nx;
    logic [IDX_W-1:0]   w_start;
    logic               w_force;
    logic               w_valid;
    logic [IDX_W-1:0]   w_idx;
    logic               w_stall;
    logic               w_xfer;

    assign w_owner_oh = {{(N_PORTS-1){1'b0}}, 1'b1} << r_owner;
    assign w_ptr_nx   = (r_rr_ptr == IDX_W'(N_PORTS-1)) ? '0 : r_rr_ptr + 1'b1;
    assign w_own_nx   = (r_owner  == IDX_W'(N_PORTS-1)) ? '0 : r_owner  + 1'b1;
    assign w_stall    = r_rts & ~dcts;
    assign w_xfer     = r_rts &  dcts;

    assign w_start = (r_state == ST_IDLE) ? w_ptr_nx :
                     (w_force             ? w_own_nx : r_owner);

    rr_priority_pick #(.N_PORTS(N_PORTS), .IDX_W(IDX_W)) u_pick (
        .i_req   (req),
        .i_start (w_start),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

`ifdef ARB_HOLD_LIMIT_EN
    logic [HOLD_W-1:0] r_hold_cnt;

    // Rotation is only forced at a transfer edge, so the owner gets
    // 1 + HOLD_MAX grants before yielding.
    assign w_force = (r_state == ST_OWN) && r_rts &&
                     (r_hold_cnt == HOLD_W'(HOLD_MAX)) && |(req & ~w_owner_oh);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_cnt <= '0;
        end else if (!w_stall) begin
            if (!w_valid || r_state == ST_IDLE || w_idx != r_owner)
                r_hold_cnt <= '0;
            else if (w_xfer && r_hold_cnt != HOLD_W'(HOLD_MAX))
                r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end
`else
    logic w_unused_hold;
    assign w_force       = 1'b0;
    assign w_unused_hold = (HOLD_MAX > 255);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= IDX_W'(N_PORTS-1);
            r_rts    <= 1'b0;
        end else begin
            // A committed winner waits out the handshake before re-arbitrating.
            if (!w_stall) begin
                if (w_valid) begin
                    r_state  <= ST_OWN;
                    r_owner  <= w_idx;
                    r_rr_ptr <= w_idx;
                end else begin
                    r_state  <= ST_IDLE;
                end
            end
            if (r_state == ST_IDLE)
                r_rts <= 1'b0;
            else
                r_rts <= ~w_xfer;
        end
    end

    assign xbar_sel = (r_state == ST_OWN) ? w_owner_oh : '0;
    assign grant    = w_xfer ? xbar_sel : '0;
    assign rts      = r_rts;
    assign busy     = (r_state != ST_IDLE);

endmodule
